// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write path: MCB instruction encodings,
// scheduler state encoding and MCB port geometry.
package vram_pkg;

  localparam logic [2:0] MCB_WR      = 3'b000;
  localparam logic [2:0] MCB_RD      = 3'b001;
  localparam logic [2:0] MCB_WR_AP   = 3'b010;
  localparam logic [2:0] MCB_RD_AP   = 3'b011;
  localparam logic [2:0] MCB_REFRESH = 3'b100;

  localparam int MCB_FIFO_DEPTH = 64;
  localparam int MCB_BL_W       = 6;

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    IDLE     = 2'd1,
    FILL     = 2'd2,
    ISSUE    = 2'd3
  } state_t;

endpackage

// File: rtl/vram_write_scheduler.sv
// Packs pixel writes into MCB p1 write bursts (one command per contiguous run).
// Optional idle auto-flush of partial bursts: define VRAM_WRITE_TIMEOUT_EN.
module vram_write_scheduler
  import vram_pkg::*;
#(
  parameter int BURST_LEN = 32,
  parameter int WADDR_W   = 28,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  input  logic                px_valid,
  output logic                px_ready,
  input  logic [WADDR_W-1:0]  px_addr,
  input  logic [31:0]         px_data,
  input  logic                flush,
  output logic                busy,
  output logic                cmd_en,
  output logic [2:0]          cmd_instr,
  output logic [MCB_BL_W-1:0] cmd_bl,
  output logic [29:0]         cmd_byte_addr,
  input  logic                cmd_full,
  output logic                wr_en,
  output logic [31:0]         wr_data,
  output logic [3:0]          wr_mask,
  input  logic                wr_full,
  output state_t              dbg_state
);

  // Handshake: a pixel transfers on a rising edge where px_valid && px_ready;
  // px_valid may rise at any time, px_ready never depends combinationally on px_valid.

  state_t               state_q, state_d;
  logic [WADDR_W-1:0]   base_q;
  logic [WADDR_W-1:0]   next_addr_q;
  logic [6:0]           count_q;
  logic                 pending_q;
  logic [WADDR_W-1:0]   pend_addr_q;
  logic [31:0]          pend_data_q;

  logic                 accept;
  logic                 brk;
  logic                 burst_full;
  logic                 tmo_hit;

  assign brk        = (state_q == FILL) && (px_addr != next_addr_q);
  assign burst_full = (count_q == 7'(BURST_LEN));

`ifdef VRAM_WRITE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Idle-cycle counter; only runs while a partial burst is open in FILL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q != FILL || accept) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_W'(TIMEOUT - 1)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == FILL) && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_CAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    px_ready = 1'b0;
    cmd_en   = 1'b0;
    accept   = 1'b0;
    case (state_q)
      WAIT_CAL: begin
        if (calib_done) state_d = IDLE;
      end
      IDLE: begin
        px_ready = !wr_full && !pending_q;
        accept   = px_valid && px_ready;
        if (accept) state_d = FILL;
      end
      FILL: begin
        px_ready = !wr_full && !pending_q && !burst_full;
        accept   = px_valid && px_ready;
        if (accept && brk) begin
          state_d = ISSUE;
        end else if (count_q != 7'd0 && (burst_full || flush || tmo_hit)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Holding off while wr_en is high keeps the last data word ahead of
        // its command when a word and flush arrive in the same cycle.
        cmd_en = !cmd_full && !wr_en;
        if (cmd_en) state_d = pending_q ? FILL : IDLE;
      end
      default: state_d = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q      <= '0;
      next_addr_q <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept && !brk) begin
        wr_en   <= 1'b1;
        wr_data <= px_data;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_q      <= px_addr;
            next_addr_q <= px_addr + WADDR_W'(1);
            count_q     <= 7'd1;
          end
        end
        FILL: begin
          if (accept) begin
            if (brk) begin
              pending_q   <= 1'b1;
              pend_addr_q <= px_addr;
              pend_data_q <= px_data;
            end else begin
              count_q     <= count_q + 7'd1;
              next_addr_q <= next_addr_q + WADDR_W'(1);
            end
          end
        end
        ISSUE: begin
          if (cmd_en) begin
            count_q <= 7'd0;
            if (pending_q) begin
              // The word that broke the run opens the next burst.
              base_q      <= pend_addr_q;
              next_addr_q <= pend_addr_q + WADDR_W'(1);
              count_q     <= 7'd1;
              pending_q   <= 1'b0;
              wr_en       <= 1'b1;
              wr_data     <= pend_data_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_instr     = MCB_WR;
  assign wr_mask       = 4'b0000;
  assign cmd_bl        = cmd_en ? MCB_BL_W'(count_q - 7'd1) : '0;
  assign cmd_byte_addr = cmd_en ? 30'({base_q, 2'b00}) : '0;
  assign busy          = (count_q != 7'd0) || (state_q == ISSUE) || pending_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler with write/command scoreboards.
// Build with VRAM_WRITE_TIMEOUT_EN to include the auto-flush latency check.
module tb_vram_write_scheduler;
  import vram_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        calib_done = 1'b0;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [27:0] px_addr = '0;
  logic [31:0] px_data = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full = 1'b0;
  state_t      dbg_state;

  vram_write_scheduler #(.BURST_LEN(32), .WADDR_W(28), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data),
    .flush(flush), .busy(busy),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_cmd    = 0;

  logic [31:0] exp_q[$];
  logic [35:0] exp_cmd_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every MCB push/command is checked against the expected queues
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        n_wr++;
        check("wr_mask", 64'(wr_mask), 64'h0);
        if (exp_q.size() == 0) check("wr_unexpected", 64'(wr_en), 64'h0);
        else check("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
      end
      if (cmd_en) begin
        n_cmd++;
        check("cmd_instr", 64'(cmd_instr), 64'(MCB_WR));
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_en), 64'h0);
        else check("cmd_bl_addr", 64'({cmd_bl, cmd_byte_addr}), 64'(exp_cmd_q.pop_front()));
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send_px(input logic [27:0] a, input logic [31:0] d, input bit fl);
    int n = 0;
    px_valid = 1'b1; px_addr = a; px_data = d; flush = fl;
    exp_q.push_back(d);
    @(negedge clk);
    while (!px_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("px_accept_timeout", 64'(px_ready), 64'h1);
    @(posedge clk); #1;
    px_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_cmds(input string tag, input int target);
    int n = 0;
    while (n_cmd < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n_cmd), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    @(negedge clk);
    check("rst_px_ready", 64'(px_ready), 64'h0);
    check("rst_cmd_en", 64'(cmd_en), 64'h0);
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_cmd_addr", 64'({cmd_bl, cmd_byte_addr}), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(WAIT_CAL));
    @(posedge clk); #1;
    reset = 1'b1;

    // no calibration: requests are held off
    px_valid = 1'b1; px_addr = 28'h100; px_data = 32'hA000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nocal_px_ready", 64'(px_ready), 64'h0);
    end
    check("nocal_wr_count", 64'(n_wr), 64'h0);
    @(posedge clk); #1;
    calib_done = 1'b1;
    n = 0;
    @(negedge clk);
    while (!px_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("cal_ready_latency", 64'(n), 64'h1);
    exp_q.push_back(32'hA000_0100);
    @(posedge clk); #1;
    px_valid = 1'b0;

    // full 32-word burst at 0x100..0x11F
    exp_cmd_q.push_back({6'd31, 30'h400});
    for (int i = 1; i < 32; i++) send_px(28'h100 + 28'(i), 32'hA000_0100 + 32'(i), 1'b0);
    wait_cmds("burst32_cmd", 1);
    check("burst32_wr_count", 64'(n_wr), 64'd32);

    // address break then flush
    exp_cmd_q.push_back({6'd4, 30'h40});
    exp_cmd_q.push_back({6'd0, 30'h200});
    for (int i = 0; i < 5; i++) send_px(28'h10 + 28'(i), 32'hB000_0010 + 32'(i), 1'b0);
    send_px(28'h80, 32'hB000_0080, 1'b0);
    wait_cmds("break_cmd", 2);
    idle(1);
    check("break_busy", 64'(busy), 64'h1);
    pulse_flush();
    wait_cmds("break_flush_cmd", 3);
    check("break_wr_count", 64'(n_wr), 64'd38);

    // command FIFO back-pressure; last word arrives with flush
    cmd_full = 1'b1;
    exp_cmd_q.push_back({6'd1, 30'hC00});
    send_px(28'h300, 32'hC000_0300, 1'b0);
    send_px(28'h301, 32'hC000_0301, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_cmd_en", 64'(cmd_en), 64'h0);
      check("hold_px_ready", 64'(px_ready), 64'h0);
      @(posedge clk); #1;
    end
    check("hold_state", 64'(dbg_state), 64'(ISSUE));
    cmd_full = 1'b0;
    wait_cmds("hold_release_cmd", 4);
    idle(5);
    check("hold_single_cmd", 64'(n_cmd), 64'd4);

    // reset in the middle of a 7-word burst
    for (int i = 0; i < 7; i++) send_px(28'h500 + 28'(i), 32'hD000_0500 + 32'(i), 1'b0);
    idle(2);
    check("midfill_state", 64'(dbg_state), 64'(FILL));
    check("midfill_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_px_ready", 64'(px_ready), 64'h0);
    check("midrst_wr_en", 64'(wr_en), 64'h0);
    check("midrst_state", 64'(dbg_state), 64'(WAIT_CAL));
    idle(3);
    reset = 1'b1;
    idle(3);
    check("midrst_no_cmd", 64'(n_cmd), 64'd4);
    check("postrst_state", 64'(dbg_state), 64'(IDLE));

    // address wrap counts as contiguous
    exp_cmd_q.push_back({6'd1, 30'h3FFF_FFFC});
    send_px(28'hFFF_FFFF, 32'hE000_0001, 1'b0);
    send_px(28'h000_0000, 32'hE000_0002, 1'b1);
    wait_cmds("wrap_cmd", 5);

    // flush with nothing open does nothing
    idle(2);
    pulse_flush();
    idle(4);
    check("idle_flush_cmds", 64'(n_cmd), 64'd5);
    check("idle_flush_busy", 64'(busy), 64'h0);
    check("idle_flush_state", 64'(dbg_state), 64'(IDLE));

`ifdef VRAM_WRITE_TIMEOUT_EN
    // partial burst auto-flushed after the idle limit
    exp_cmd_q.push_back({6'd2, 30'h1800});
    for (int i = 0; i < 3; i++) send_px(28'h600 + 28'(i), 32'hF000_0600 + 32'(i), 1'b0);
    n = 0;
    @(negedge clk);
    while (!cmd_en && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("tmo_latency", 64'(n), 64'd255);
    idle(3);
    check("tmo_cmds", 64'(n_cmd), 64'd6);
`endif

    idle(3);
    check("exp_wr_drained", 64'(exp_q.size()), 64'h0);
    check("exp_cmd_drained", 64'(exp_cmd_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
